// File: rtl/ballot_encryptor_pkg.sv
// Shared types and size derivations for the ballot encryptor.
package ballot_encryptor_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        REQUEST      = 3'd1,
        STREAM_PLAIN = 3'd2,
        STREAM_CAST  = 3'd3,
        NEXT         = 3'd4
    } state_t;

    // Blocks per ciphertext: the ciphertext lives modulo n^2, so it is twice the modulus width.
    function automatic int num_blocks(input int register_size, input int bits_in_num);
        return (2 * bits_in_num) / register_size;
    endfunction

    // Candidate index width, never narrower than one bit.
    function automatic int cand_w(input int num_candidates);
        return (num_candidates > 1) ? $clog2(num_candidates) : 1;
    endfunction

    // Block counters must reach NUM_BLOCKS itself so "one too many" is detectable.
    function automatic int cnt_w(input int blocks);
        return $clog2(blocks + 1);
    endfunction

endpackage

// File: rtl/ballot_encryptor_checker.sv
// Captures the accepted ballot and judges it: at most one vote set is legal.
module ballot_checker #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] ballot,
    output logic [WIDTH-1:0] ballot_q,
    output logic             bad,
    output logic             error_pulse
);

    // True when no more than one bit of the vector is set (abstain is legal).
    function automatic logic at_most_one(input logic [WIDTH-1:0] v);
        return (v & (v - WIDTH'(1))) == {WIDTH{1'b0}};
    endfunction

    // Register the ballot and its verdict on acceptance; the error pulse lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ballot_q    <= {WIDTH{1'b0}};
            bad         <= 1'b0;
            error_pulse <= 1'b0;
        end else if (load) begin
            ballot_q    <= ballot;
            bad         <= !at_most_one(ballot);
            error_pulse <= !at_most_one(ballot);
        end else begin
            error_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/ballot_encryptor.sv
// Ballot encryptor: walks every candidate, streams r^n for each, and routes the
// voted candidate's blocks through the external multiply/reduce path.
module ballot_encryptor
    import ballot_encryptor_pkg::*;
#(
    parameter int REGISTER_SIZE  = 32,
    parameter int BITS_IN_NUM    = 4096,
    parameter int NUM_CANDIDATES = 4
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic [NUM_CANDIDATES-1:0]             ballot_in,
    input  logic                                  ballot_valid_in,
    output logic                                  ballot_ready_out,
    input  logic [REGISTER_SIZE-1:0]              rn_data_in,
    input  logic                                  rn_valid_in,
    output logic                                  rn_request_out,
    output logic [REGISTER_SIZE-1:0]              cast_data_out,
    output logic                                  cast_valid_out,
    input  logic [REGISTER_SIZE-1:0]              cast_data_in,
    input  logic                                  cast_valid_in,
    output logic [REGISTER_SIZE-1:0]              data_out,
    output logic                                  valid_out,
    output logic                                  last_out,
    output logic [cand_w(NUM_CANDIDATES)-1:0]     cand_idx_out,
    output logic                                  ballot_error_out,
    output logic                                  protocol_error_out,
    output logic                                  busy_out
);

    localparam int NUM_BLOCKS = num_blocks(REGISTER_SIZE, BITS_IN_NUM);
    localparam int CAND_W     = cand_w(NUM_CANDIDATES);
    localparam int CNT_W      = cnt_w(NUM_BLOCKS);

    localparam logic [CNT_W-1:0]  LAST_BLK  = CNT_W'(NUM_BLOCKS - 1);
    localparam logic [CNT_W-1:0]  FULL_BLK  = CNT_W'(NUM_BLOCKS);
    localparam logic [CAND_W-1:0] LAST_CAND = CAND_W'(NUM_CANDIDATES - 1);

    state_t                      state_r;
    state_t                      next_state_s;
    logic [CAND_W-1:0]           cand_r;
    logic [CNT_W-1:0]            in_cnt_r;
    logic [CNT_W-1:0]            out_cnt_r;

    logic [NUM_CANDIDATES-1:0]   ballot_q_s;
    logic                        ballot_bad_s;
    logic                        accept_s;
    logic                        in_stream_s;
    logic                        rn_take_s;
    logic                        cast_take_s;
    logic                        rn_drop_s;
    logic                        cast_drop_s;
    logic                        emit_s;
    logic                        emit_last_s;
    logic [REGISTER_SIZE-1:0]    emit_data_s;
    logic                        cand_bit_s;

    assign accept_s    = ballot_valid_in && (state_r == IDLE);
    assign in_stream_s = (state_r == STREAM_PLAIN) || (state_r == STREAM_CAST);
    // Blocks past the per-candidate quota, or arriving in the wrong state, are dropped.
    assign rn_take_s   = rn_valid_in && in_stream_s && (in_cnt_r < FULL_BLK);
    assign cast_take_s = cast_valid_in && (state_r == STREAM_CAST) && (out_cnt_r < FULL_BLK);
    assign rn_drop_s   = rn_valid_in && !rn_take_s;
    assign cast_drop_s = cast_valid_in && !cast_take_s;
    assign cand_bit_s  = ballot_q_s[cand_r];
    assign emit_last_s = emit_s && (out_cnt_r == LAST_BLK);

    ballot_checker #(
        .WIDTH (NUM_CANDIDATES)
    ) u_checker (
        .clk         (clk_in),
        .rst_n       (rst_n_in),
        .load        (accept_s),
        .ballot      (ballot_in),
        .ballot_q    (ballot_q_s),
        .bad         (ballot_bad_s),
        .error_pulse (ballot_error_out)
    );

    // Select which input feeds the ciphertext output in the current stream state.
    always_comb begin
        emit_s      = 1'b0;
        emit_data_s = {REGISTER_SIZE{1'b0}};
        if (state_r == STREAM_PLAIN) begin
            emit_s      = rn_take_s;
            emit_data_s = rn_data_in;
        end else if (state_r == STREAM_CAST) begin
            emit_s      = cast_take_s;
            emit_data_s = cast_data_in;
        end else begin
            emit_s      = 1'b0;
            emit_data_s = {REGISTER_SIZE{1'b0}};
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a rejected ballot bails out of REQUEST before any request is made.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = REQUEST;
                else          next_state_s = IDLE;
            end
            REQUEST: begin
                if (ballot_bad_s)    next_state_s = IDLE;
                else if (cand_bit_s) next_state_s = STREAM_CAST;
                else                 next_state_s = STREAM_PLAIN;
            end
            STREAM_PLAIN, STREAM_CAST: begin
                if (emit_last_s) next_state_s = NEXT;
                else             next_state_s = state_r;
            end
            NEXT: begin
                if (cand_r == LAST_CAND) next_state_s = IDLE;
                else                     next_state_s = REQUEST;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State-decoded handshake/status outputs.
    always_comb begin
        ballot_ready_out = 1'b0;
        busy_out         = 1'b1;
        case (state_r)
            IDLE: begin
                ballot_ready_out = 1'b1;
                busy_out         = 1'b0;
            end
            default: begin
                ballot_ready_out = 1'b0;
                busy_out         = 1'b1;
            end
        endcase
    end

    // Candidate index and the independent input/output block counters.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cand_r    <= {CAND_W{1'b0}};
            in_cnt_r  <= {CNT_W{1'b0}};
            out_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == IDLE) begin
            cand_r    <= {CAND_W{1'b0}};
            in_cnt_r  <= {CNT_W{1'b0}};
            out_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == NEXT) begin
            in_cnt_r  <= {CNT_W{1'b0}};
            out_cnt_r <= {CNT_W{1'b0}};
            if (cand_r != LAST_CAND) begin
                cand_r <= cand_r + CAND_W'(1);
            end
        end else begin
            if (rn_take_s) begin
                in_cnt_r <= in_cnt_r + CNT_W'(1);
            end
            if (emit_s) begin
                out_cnt_r <= out_cnt_r + CNT_W'(1);
            end
        end
    end

    // Registered datapath outputs: request pulse, cast forwarding, ciphertext stream, sticky error.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rn_request_out     <= 1'b0;
            cast_valid_out     <= 1'b0;
            cast_data_out      <= {REGISTER_SIZE{1'b0}};
            valid_out          <= 1'b0;
            last_out           <= 1'b0;
            data_out           <= {REGISTER_SIZE{1'b0}};
            cand_idx_out       <= {CAND_W{1'b0}};
            protocol_error_out <= 1'b0;
        end else begin
            rn_request_out <= (state_r == REQUEST) && !ballot_bad_s;
            cast_valid_out <= rn_take_s && (state_r == STREAM_CAST);
            if (rn_take_s && (state_r == STREAM_CAST)) begin
                cast_data_out <= rn_data_in;
            end
            valid_out <= emit_s;
            last_out  <= emit_last_s;
            if (emit_s) begin
                data_out     <= emit_data_s;
                cand_idx_out <= cand_r;
            end
            protocol_error_out <= protocol_error_out | rn_drop_s | cast_drop_s;
        end
    end

endmodule
